// File: rtl/pu_riscv_wb_mmio_arbiter_pkg.sv
// Shared types and Wishbone cycle-type constants for the MMIO arbiter.
package pu_riscv_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    TOERR = 2'd2
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/pu_riscv_wb_mmio_arbiter_if.sv
// Wishbone bundle between NUM_MASTERS requesters, the arbiter and the single MMIO slave.
interface pu_riscv_wb_mmio_arbiter_if #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int NUM_MASTERS = 2
);

  // Handshake: cyc requests and holds the bus, stb marks a valid beat, and
  // exactly one of ack/err/rty in a cycle with stb high completes that beat.
  logic [NUM_MASTERS-1:0][HADDR_SIZE-1:0] m_adr_i;
  logic [NUM_MASTERS-1:0][HDATA_SIZE-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0][3:0]            m_sel_i;
  logic [NUM_MASTERS-1:0]                 m_we_i;
  logic [NUM_MASTERS-1:0]                 m_cyc_i;
  logic [NUM_MASTERS-1:0]                 m_stb_i;
  logic [NUM_MASTERS-1:0][2:0]            m_cti_i;
  logic [NUM_MASTERS-1:0][1:0]            m_bte_i;
  logic [HDATA_SIZE-1:0]                  m_dat_o;
  logic [NUM_MASTERS-1:0]                 m_ack_o;
  logic [NUM_MASTERS-1:0]                 m_err_o;
  logic [NUM_MASTERS-1:0]                 m_rty_o;

  logic [HADDR_SIZE-1:0] s_adr_o;
  logic [HDATA_SIZE-1:0] s_dat_o;
  logic [3:0]            s_sel_o;
  logic                  s_we_o;
  logic [2:0]            s_cti_o;
  logic [1:0]            s_bte_o;
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic [HDATA_SIZE-1:0] s_dat_i;
  logic                  s_ack_i;
  logic                  s_err_i;
  logic                  s_rty_i;

  modport arbiter (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o
  );

  modport slave (
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

endinterface

// File: rtl/pu_riscv_wb_mmio_arbiter_rr.sv
// Combinational round-robin picker: first requester after last_grant, cyclically.
module pu_riscv_rr_arbiter #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [GW-1:0] grant_idx
);

  always_comb begin
    int            pos;
    logic [GW-1:0] idx;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    // Scan last_grant+1 .. last_grant+N so the previous winner is tried last.
    for (int i = 1; i <= N; i++) begin
      pos = int'(last_grant) + i;
      if (pos >= N) pos = pos - N;
      idx = GW'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/pu_riscv_wb_mmio_arbiter.sv
// Round-robin Wishbone arbiter for the shared MMIO slave, with a per-access watchdog
// that answers ERR to the granted master when the slave never responds.
module pu_riscv_wb_mmio_arbiter
  import pu_riscv_wb_arb_pkg::*;
#(
  parameter int HADDR_SIZE     = 32,
  parameter int HDATA_SIZE     = 32,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  pu_riscv_wb_mmio_arbiter_if.arbiter bus,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o,
  output arb_state_t                  state_o
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  arb_state_t             state;
  logic [GW-1:0]          gidx;
  logic [GW-1:0]          last_grant;
  logic [CW-1:0]          cnt;
  logic [NUM_MASTERS-1:0] pick;
  logic [GW-1:0]          pick_idx;
  logic                   g_cyc;
  logic                   g_stb;
  logic                   s_resp;
  logic                   active;
  logic                   to_hit;

  pu_riscv_rr_arbiter #(
    .N  (NUM_MASTERS),
    .GW (GW)
  ) u_rr (
    .req        (bus.m_cyc_i),
    .last_grant (last_grant),
    .grant      (pick),
    .grant_idx  (pick_idx)
  );

  assign g_cyc   = bus.m_cyc_i[gidx];
  assign g_stb   = bus.m_stb_i[gidx];
  assign s_resp  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign active  = (state != IDLE) && g_cyc;
  // TOERR is the terminal-count cycle; a slave response landing here still wins.
  assign to_hit  = (state == TOERR) && g_cyc && !s_resp;
  assign state_o = state;

  always_comb begin
    bus.s_adr_o = bus.m_adr_i[gidx];
    bus.s_dat_o = bus.m_dat_i[gidx];
    bus.s_sel_o = bus.m_sel_i[gidx];
    bus.s_we_o  = bus.m_we_i[gidx];
    bus.s_cti_o = bus.m_cti_i[gidx];
    bus.s_bte_o = bus.m_bte_i[gidx];
    bus.s_cyc_o = active;
    bus.s_stb_o = (state == BUSY) && g_cyc && g_stb;
    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    if (active) begin
      bus.m_ack_o[gidx] = bus.s_ack_i;
      bus.m_rty_o[gidx] = bus.s_rty_i;
      bus.m_err_o[gidx] = bus.s_err_i | to_hit;
    end
    timeout_o = to_hit;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      grant_o    <= '0;
      gidx       <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|bus.m_cyc_i) begin
            state   <= BUSY;
            grant_o <= pick;
            gidx    <= pick_idx;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state      <= IDLE;
            grant_o    <= '0;
            last_grant <= gidx;
            cnt        <= '0;
          end else if (!g_stb || s_resp) begin
            cnt <= '0;
          end else begin
            if (cnt == CNT_LAST) state <= TOERR;
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          end
        end
        TOERR: begin
          cnt <= '0;
          if (!g_cyc) begin
            state      <= IDLE;
            grant_o    <= '0;
            last_grant <= gidx;
          end else begin
            state <= BUSY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_riscv_wb_mmio_arbiter.sv
// Bench for pu_riscv_wb_mmio_arbiter: directed reset/timeout/burst cases plus
// randomized contention rounds scored against a round-robin order model.
module tb_pu_riscv_wb_mmio_arbiter;
  import pu_riscv_wb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 2;
  localparam int TO = 8;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [NM-1:0] grant_o;
  logic          timeout_o;
  arb_state_t    state_o;

  int n_checks = 0;
  int n_errors = 0;
  int model_last;
  logic [NM-1:0] exp_q[$];

  pu_riscv_wb_mmio_arbiter_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .NUM_MASTERS(NM)) bus ();

  pu_riscv_wb_mmio_arbiter #(
    .HADDR_SIZE(AW), .HDATA_SIZE(DW), .NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus),
    .grant_o   (grant_o),
    .timeout_o (timeout_o),
    .state_o   (state_o)
  );

  // clock / watchdog
  always #5 HCLK = ~HCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
    bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
  endtask

  // Model: masters requesting together are served cyclically from last winner + 1.
  task automatic expect_round(input logic [NM-1:0] set);
    int m;
    int last;
    last = model_last;
    for (int k = 1; k <= NM; k++) begin
      m = (model_last + k) % NM;
      if (set[m]) begin
        exp_q.push_back(NM'(1) << m);
        last = m;
      end
    end
    model_last = last;
  endtask

  function automatic int onehot_idx(input logic [NM-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NM; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic wait_grant(input string tag, output logic [NM-1:0] expg, output logic ok);
    ok = 1'b0;
    expg = '0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge HCLK);
      if (bus.s_cyc_o) ok = 1'b1;
      else next_cycle();
    end
    if (!ok) check({tag, "_grant_wait"}, 1, 0);
    else if (exp_q.size() == 0) begin
      check({tag, "_exp_q_underflow"}, 1, 0);
      ok = 1'b0;
    end else begin
      expg = exp_q.pop_front();
      check({tag, "_grant"}, grant_o, expg);
    end
  endtask

  task automatic run_round(input logic [NM-1:0] set, input logic directed);
    logic [AW-1:0] adr [NM];
    logic [DW-1:0] dat [NM];
    logic          we  [NM];
    logic [NM-1:0] pending, expg;
    logic [DW-1:0] rdat;
    logic          resp_on, first;
    int            cur, delay, age, gap, budget, rtype;
    expect_round(set);
    for (int i = 0; i < NM; i++) begin
      adr[i] = directed ? 32'h8000_1080 : $urandom;
      dat[i] = directed ? 32'h0000_0041 : $urandom;
      we[i]  = directed ? 1'b1 : 1'($urandom_range(0, 1));
      bus.m_adr_i[i] = adr[i];
      bus.m_dat_i[i] = dat[i];
      bus.m_we_i[i]  = we[i];
      bus.m_sel_i[i] = 4'hf;
      bus.m_cti_i[i] = CTI_CLASSIC;
      bus.m_bte_i[i] = BTE_LINEAR;
    end
    bus.m_cyc_i = set;
    bus.m_stb_i = set;
    pending = set;
    cur = -1; gap = 0; budget = 0; resp_on = 1'b0; first = 1'b1;
    expg = '0; delay = 1; age = 0; rtype = 0; rdat = '0;
    while (pending != '0 && budget < 200) begin
      @(negedge HCLK);
      budget++;
      if (cur < 0) begin
        if (bus.s_cyc_o) begin
          if (exp_q.size() == 0) begin
            check("exp_q_underflow", 1, 0);
            break;
          end
          expg = exp_q.pop_front();
          cur  = onehot_idx(expg);
          check("grant", grant_o, expg);
          check(first ? "grant_latency" : "release_bubble", gap, first ? 1 : 2);
          check("s_adr", bus.s_adr_o, adr[cur]);
          check("s_dat", bus.s_dat_o, dat[cur]);
          check("s_we", bus.s_we_o, we[cur]);
          check("s_stb", bus.s_stb_o, 1);
          first = 1'b0;
          delay = directed ? 1 : $urandom_range(1, 4);
          age = 0;
        end else begin
          gap++;
        end
      end else if (resp_on) begin
        check("resp_route", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o},
              {(rtype <= 2) ? expg : '0, (rtype == 3) ? expg : '0, (rtype == 4) ? expg : '0});
        check("rd_data", bus.m_dat_o, rdat);
        check("resp_grant", grant_o, expg);
        check("resp_no_timeout", timeout_o, 0);
      end else begin
        check("hold_grant", grant_o, expg);
        check("hold_no_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
      end
      next_cycle();
      if (cur >= 0) begin
        if (resp_on) begin
          bus.m_cyc_i = bus.m_cyc_i & ~expg;
          bus.m_stb_i = bus.m_stb_i & ~expg;
          bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
          resp_on = 1'b0;
          pending = pending & ~expg;
          cur = -1;
          gap = 0;
        end else begin
          age++;
          if (age == delay) begin
            rtype = directed ? 0 : $urandom_range(0, 4);
            rdat  = $urandom;
            bus.s_dat_i = rdat;
            bus.s_ack_i = (rtype <= 2);
            bus.s_err_i = (rtype == 3);
            bus.s_rty_i = (rtype == 4);
            resp_on = 1'b1;
          end
        end
      end
    end
    if (pending != '0) check("round_timeout", pending, 0);
    @(negedge HCLK);
    check("release_s_cyc", bus.s_cyc_o, 0);
    next_cycle();
  endtask

  task automatic run_timeout(input logic ack_at_end);
    logic [NM-1:0] expg;
    logic ok;
    expect_round(2'b10);
    bus.m_adr_i[1] = $urandom;
    bus.m_we_i[1]  = 1'b0;
    bus.m_cti_i[1] = CTI_CLASSIC;
    bus.m_cyc_i = 2'b10;
    bus.m_stb_i = 2'b10;
    wait_grant(ack_at_end ? "ack_tc" : "timeout", expg, ok);
    if (ok) begin
      for (int n = 1; n <= TO; n++) begin
        if (n > 1) @(negedge HCLK);
        if (n < TO) begin
          check("to_stb_held", bus.s_stb_o, 1);
          check("to_no_resp", {bus.m_ack_o, bus.m_err_o, timeout_o}, 0);
        end else if (ack_at_end) begin
          check("tc_ack", bus.m_ack_o, 2'b10);
          check("tc_no_err", bus.m_err_o, 0);
          check("tc_no_timeout", timeout_o, 0);
        end else begin
          check("to_err", bus.m_err_o, 2'b10);
          check("to_pulse", timeout_o, 1);
          check("to_stb_forced", bus.s_stb_o, 0);
          check("to_no_ack", bus.m_ack_o, 0);
        end
        next_cycle();
        if (n == TO - 1 && ack_at_end) bus.s_ack_i = 1'b1;
      end
    end
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    @(negedge HCLK);
    check("to_pulse_single", {timeout_o, bus.m_err_o}, 0);
    check("to_release", bus.s_cyc_o, 0);
    next_cycle();
  endtask

  task automatic run_reset_burst();
    logic [NM-1:0] expg;
    logic ok;
    expect_round(2'b01);
    bus.m_adr_i[0] = 32'h8000_1000;
    bus.m_we_i[0]  = 1'b1;
    bus.m_cti_i[0] = CTI_INCR;
    bus.m_bte_i[0] = BTE_LINEAR;
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    wait_grant("burst", expg, ok);
    for (int b = 1; b <= 2; b++) begin
      next_cycle();
      bus.s_ack_i = 1'b1;
      @(negedge HCLK);
      check("burst_ack", bus.m_ack_o, 2'b01);
      check("burst_cti", bus.s_cti_o, CTI_INCR);
    end
    next_cycle();
    bus.s_ack_i = 1'b0;
    HRESET = 1'b1;
    @(negedge HCLK);
    check("burst_pre_reset_cyc", bus.s_cyc_o, 1);
    next_cycle();
    HRESET = 1'b0;
    model_last = NM - 1;
    exp_q.delete();
    expect_round(2'b01);
    @(negedge HCLK);
    check("burst_reset_cyc", bus.s_cyc_o, 0);
    check("burst_reset_grant", grant_o, 0);
    check("burst_reset_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    next_cycle();
    @(negedge HCLK);
    check("burst_regrant_cyc", bus.s_cyc_o, 1);
    if (exp_q.size() != 0) check("burst_regrant", grant_o, exp_q.pop_front());
    else check("burst_exp_q_underflow", 1, 0);
    next_cycle();
    bus.m_cti_i[0] = CTI_EOB;
    bus.s_ack_i = 1'b1;
    @(negedge HCLK);
    check("burst_eob_ack", bus.m_ack_o, 2'b01);
    next_cycle();
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_cti_i[0] = CTI_CLASSIC;
    next_cycle();
  endtask

  // main sequence and final report
  initial begin
    drive_idle();
    HRESET = 1'b1;
    model_last = NM - 1;
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    for (int r = 0; r < 2; r++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      check("reset_grant", grant_o, 0);
      check("reset_s_cyc_stb", {bus.s_cyc_o, bus.s_stb_o}, 0);
      check("reset_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o, timeout_o}, 0);
      check("reset_state", state_o, IDLE);
    end
    next_cycle();
    HRESET = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    next_cycle();

    run_round(2'b01, 1'b1);
    run_round(2'b11, 1'b0);
    run_round(2'b11, 1'b0);
    run_timeout(1'b0);
    run_timeout(1'b1);
    for (int r = 0; r < 30; r++) run_round(NM'($urandom_range(1, 3)), 1'b0);
    run_reset_burst();
    run_round(2'b11, 1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
